// File: rtl/seg7_pkg.sv
// Shared definitions for the dual-digit display controller.
//   state_e   : sequencer states
//   SEG_DARK  : active-low pad value with every segment off
//   SEG_CODES : active-high 7-segment codes for 0-F, bit6=A ... bit0=G
package seg7_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrvLo,
    StDrvHi,
    StCapHi
  } state_e;

  localparam logic [6:0] SEG_DARK = 7'h7F;

  localparam logic [6:0] SEG_CODES [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Reference mapping expected from the external shared decoder.
  function automatic logic [6:0] seg_code(input logic [3:0] num);
    return SEG_CODES[num];
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Blink phase generator.
//   i_Clk    : system clock
//   i_Rst_L  : asynchronous active-low reset
//   i_En     : run the timer; when low the counter and phase are held at 0
//   o_Phase  : registered phase, toggles every BLINK_CYCLES enabled cycles
module blink_timer #(
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_En,
  output logic o_Phase
);

  localparam int unsigned CntW = $clog2(BLINK_CYCLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(BLINK_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt_q   <= '0;
      o_Phase <= 1'b0;
    end else if (!i_En) begin
      cnt_q   <= '0;
      o_Phase <= 1'b0;
    end else if (cnt_q == LastCnt) begin
      cnt_q   <= '0;
      o_Phase <= ~o_Phase;
    end else begin
      cnt_q   <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/dual_digit_display_ctrl.sv
// Drives two 7-segment digits from an 8-bit value through one shared,
// externally instantiated, 1-cycle registered decoder.
//   i_Clk, i_Rst_L      : clock, asynchronous active-low reset
//   i_Valid, i_Value    : value offer ([7:4] tens, [3:0] ones)
//   o_Ready             : high only in idle
//   o_Dec_Num/i_Dec_Seg : nibble to the decoder / its active-high code
//   i_Blink_En          : blink both digits
//   o_Seg1, o_Seg2      : tens / ones digit, active-low, bit6=A ... bit0=G
module dual_digit_display_ctrl
  import seg7_pkg::*;
#(
  parameter bit          LZ_BLANK     = 1'b0,
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Valid,
  input  logic [7:0] i_Value,
  output logic       o_Ready,
  output logic [3:0] o_Dec_Num,
  input  logic [6:0] i_Dec_Seg,
  input  logic       i_Blink_En,
  output logic [6:0] o_Seg1,
  output logic [6:0] o_Seg2
);

  state_e     state_q;
  logic [7:0] value_q;
  logic [6:0] ones_q;    // active-high ones code, held until commit
  logic [6:0] com1_q;    // committed active-low codes, retained under blink
  logic [6:0] com2_q;
  logic [6:0] com1_d;
  logic [6:0] com2_d;
  logic       phase;
  logic       dark;

  blink_timer #(
    .BLINK_CYCLES(BLINK_CYCLES)
  ) u_blink_timer (
    .i_Clk  (i_Clk),
    .i_Rst_L(i_Rst_L),
    .i_En   (i_Blink_En),
    .o_Phase(phase)
  );

  // Both digits change on the same edge; the tens code arrives from the
  // decoder exactly in CAP_HI.
  always_comb begin
    com1_d = com1_q;
    com2_d = com2_q;
    if (state_q == StCapHi) begin
      com2_d = ~ones_q;
      com1_d = (LZ_BLANK && (value_q[7:4] == 4'h0)) ? SEG_DARK : ~i_Dec_Seg;
    end
  end

  // Gating with i_Blink_En lets a disable relight the digits on the next edge
  // instead of waiting for the timer's phase to clear.
  assign dark = phase & i_Blink_En;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= StIdle;
      value_q   <= '0;
      ones_q    <= '0;
      com1_q    <= SEG_DARK;
      com2_q    <= SEG_DARK;
      o_Ready   <= 1'b1;
      o_Dec_Num <= '0;
      o_Seg1    <= SEG_DARK;
      o_Seg2    <= SEG_DARK;
    end else begin
      com1_q <= com1_d;
      com2_q <= com2_d;
      o_Seg1 <= dark ? SEG_DARK : com1_d;
      o_Seg2 <= dark ? SEG_DARK : com2_d;
      unique case (state_q)
        StIdle: begin
          if (i_Valid) begin
            value_q   <= i_Value;
            o_Dec_Num <= i_Value[3:0];
            o_Ready   <= 1'b0;
            state_q   <= StDrvLo;
          end
        end
        StDrvLo: begin
          o_Dec_Num <= value_q[7:4];
          state_q   <= StDrvHi;
        end
        StDrvHi: begin
          ones_q  <= i_Dec_Seg;
          state_q <= StCapHi;
        end
        StCapHi: begin
          o_Ready <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_digit_display_ctrl.sv
module tb_dual_digit_display_ctrl;

  localparam int unsigned BLINK = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid = 1'b0;
  logic       blink_en = 1'b0;
  logic [7:0] value = 8'h00;

  logic       ready0, ready1;
  logic [3:0] dnum0, dnum1;
  logic [6:0] dseg0, dseg1;
  logic [6:0] s1_0, s2_0, s1_1, s2_1;

  // Active-high decoder codes 0-F, bit6=A ... bit0=G.
  logic [6:0] dec_tab [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  always #5 clk = ~clk;

  // Board-level shared decoders, one per instance, 1-cycle registered.
  always @(posedge clk) begin
    dseg0 <= dec_tab[dnum0];
    dseg1 <= dec_tab[dnum1];
  end

  dual_digit_display_ctrl #(
    .LZ_BLANK    (1'b0),
    .BLINK_CYCLES(BLINK)
  ) u_dut_lz0 (
    .i_Clk     (clk),
    .i_Rst_L   (rst_n),
    .i_Valid   (valid),
    .i_Value   (value),
    .o_Ready   (ready0),
    .o_Dec_Num (dnum0),
    .i_Dec_Seg (dseg0),
    .i_Blink_En(blink_en),
    .o_Seg1    (s1_0),
    .o_Seg2    (s2_0)
  );

  dual_digit_display_ctrl #(
    .LZ_BLANK    (1'b1),
    .BLINK_CYCLES(BLINK)
  ) u_dut_lz1 (
    .i_Clk     (clk),
    .i_Rst_L   (rst_n),
    .i_Valid   (valid),
    .i_Value   (value),
    .o_Ready   (ready1),
    .o_Dec_Num (dnum1),
    .i_Dec_Seg (dseg1),
    .i_Blink_En(blink_en),
    .o_Seg1    (s1_1),
    .o_Seg2    (s2_1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a transfer occupies the controller for 3 cycles after
  // acceptance; the digits show the committed codes unless the blink phase
  // (enabled-cycle count / BLINK, odd) was dark going into the edge.
  int         busy;
  logic [7:0] pend;
  logic [3:0] m_dec;
  logic [6:0] m_com1 [2];
  logic [6:0] m_com2;
  logic [6:0] m_out1 [2];
  logic [6:0] m_out2;
  int         en_run;

  typedef struct {
    logic [7:0] value;
    logic [6:0] s1_lz0;
    logic [6:0] s1_lz1;
    logic [6:0] s2;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    busy      = 0;
    pend      = 8'h00;
    m_dec     = 4'h0;
    m_com1[0] = 7'h7F;
    m_com1[1] = 7'h7F;
    m_com2    = 7'h7F;
    m_out1[0] = 7'h7F;
    m_out1[1] = 7'h7F;
    m_out2    = 7'h7F;
    en_run    = 0;
  endtask

  // One clock edge plus model update; returns 1 time unit after the edge.
  task automatic step();
    logic mask;
    @(posedge clk);
    mask = (((en_run / int'(BLINK)) % 2) == 1) && blink_en;
    if (blink_en) en_run++;
    else en_run = 0;
    if (busy > 0) begin
      busy--;
      if (busy == 2) m_dec = pend[7:4];
      if (busy == 0) begin
        m_com2    = ~dec_tab[pend[3:0]];
        m_com1[0] = ~dec_tab[pend[7:4]];
        m_com1[1] = (pend[7:4] == 4'h0) ? 7'h7F : ~dec_tab[pend[7:4]];
      end
    end else if (valid) begin
      pend  = value;
      busy  = 3;
      m_dec = value[3:0];
    end
    for (int k = 0; k < 2; k++) m_out1[k] = mask ? 7'h7F : m_com1[k];
    m_out2 = mask ? 7'h7F : m_com2;
    #1;
  endtask

  task automatic cmp_model(input string tag);
    check({tag, " ready0"}, {7'b0, ready0}, {7'b0, busy == 0});
    check({tag, " ready1"}, {7'b0, ready1}, {7'b0, busy == 0});
    check({tag, " dnum0"}, {4'b0, dnum0}, {4'b0, m_dec});
    check({tag, " dnum1"}, {4'b0, dnum1}, {4'b0, m_dec});
    check({tag, " seg1_lz0"}, {1'b0, s1_0}, {1'b0, m_out1[0]});
    check({tag, " seg1_lz1"}, {1'b0, s1_1}, {1'b0, m_out1[1]});
    check({tag, " seg2_lz0"}, {1'b0, s2_0}, {1'b0, m_out2});
    check({tag, " seg2_lz1"}, {1'b0, s2_1}, {1'b0, m_out2});
  endtask

  // Offer a value for one edge, then idle until the commit.
  task automatic send(input logic [7:0] v, input string tag);
    valid = 1'b1;
    value = v;
    step();
    cmp_model({tag, " e0"});
    valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      cmp_model({tag, " wait"});
    end
  endtask

  initial begin
    int low_cnt;
    model_reset();

    vecs[0] = '{8'h3A, 7'h06, 7'h06, 7'h08};
    vecs[1] = '{8'h07, 7'h01, 7'h7F, 7'h0F};
    vecs[2] = '{8'h00, 7'h01, 7'h7F, 7'h01};
    vecs[3] = '{8'hEF, 7'h30, 7'h30, 7'h38};
    vecs[4] = '{8'hB4, 7'h60, 7'h60, 7'h4C};
    vecs[5] = '{8'h0C, 7'h01, 7'h7F, 7'h31};
    vecs[6] = '{8'h96, 7'h04, 7'h04, 7'h20};
    vecs[7] = '{8'hD8, 7'h42, 7'h42, 7'h00};
    vecs[8] = '{8'h12, 7'h4F, 7'h4F, 7'h12};
    vecs[9] = '{8'h5B, 7'h24, 7'h24, 7'h60};

    // Reset state, both during and after reset.
    #1 rst_n = 1'b0;
    #2;
    check("rst seg1", {1'b0, s1_0}, 8'h7F);
    check("rst seg2", {1'b0, s2_0}, 8'h7F);
    check("rst ready", {7'b0, ready0}, 8'h01);
    check("rst dnum", {4'b0, dnum0}, 8'h00);
    #10 rst_n = 1'b1;
    step();
    cmp_model("idle");
    step();
    cmp_model("idle");

    // 3A: decoder sequence A then 3, ready low exactly 3 cycles.
    valid = 1'b1;
    value = 8'h3A;
    step();
    check("3A dnum lo", {4'b0, dnum0}, 8'h0A);
    valid = 1'b0;
    low_cnt = ready0 ? 0 : 1;
    step();
    check("3A dnum hi", {4'b0, dnum0}, 8'h03);
    low_cnt += ready0 ? 0 : 1;
    step();
    low_cnt += ready0 ? 0 : 1;
    check("3A no early seg1", {1'b0, s1_0}, 8'h7F);
    step();
    low_cnt += ready0 ? 0 : 1;
    check("3A ready low cycles", 8'(low_cnt), 8'd3);
    check("3A seg1", {1'b0, s1_0}, 8'h06);
    check("3A seg2", {1'b0, s2_0}, 8'h08);
    cmp_model("3A");

    // Table vectors on both LZ_BLANK settings.
    foreach (vecs[i]) begin
      send(vecs[i].value, "vec");
      check($sformatf("vec%0d seg1_lz0", i), {1'b0, s1_0}, {1'b0, vecs[i].s1_lz0});
      check($sformatf("vec%0d seg1_lz1", i), {1'b0, s1_1}, {1'b0, vecs[i].s1_lz1});
      check($sformatf("vec%0d seg2", i), {1'b0, s2_0}, {1'b0, vecs[i].s2});
    end

    // Valid held high: 12 accepted at E0, EF not before E4.
    valid = 1'b1;
    value = 8'h12;
    step();
    cmp_model("b2b e0");
    value = 8'hEF;
    for (int e = 1; e <= 3; e++) begin
      step();
      cmp_model("b2b e1-3");
      check("b2b dnum not F", {7'b0, dnum0 == 4'hF}, 8'h00);
    end
    check("b2b first seg1", {1'b0, s1_0}, 8'h4F);
    check("b2b first seg2", {1'b0, s2_0}, 8'h12);
    step();
    check("b2b accept e4", {4'b0, dnum0}, 8'h0F);
    valid = 1'b0;
    for (int e = 5; e <= 7; e++) begin
      step();
      cmp_model("b2b e5-7");
    end
    check("b2b final seg1", {1'b0, s1_0}, 8'h30);
    check("b2b final seg2", {1'b0, s2_0}, 8'h38);

    // Blink with committed 55.
    send(8'h55, "blink setup");
    blink_en = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      cmp_model("blink");
      check($sformatf("blink k%0d", k), {1'b0, s2_0},
            ((k >= 5 && k <= 8) || k == 13) ? 8'h7F : 8'h24);
    end
    blink_en = 1'b0;
    step();
    check("blink off seg1", {1'b0, s1_0}, 8'h24);
    check("blink off seg2", {1'b0, s2_0}, 8'h24);
    cmp_model("blink off");

    // Randomized traffic with blink toggling.
    for (int c = 0; c < 400; c++) begin
      if (busy == 0) begin
        valid = 1'($urandom_range(0, 1));
        value = 8'($urandom);
      end else begin
        valid = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 15) == 0) blink_en = ~blink_en;
      step();
      cmp_model("rand");
    end
    valid = 1'b0;
    blink_en = 1'b0;
    send(8'h44, "pre-reset");

    // Asynchronous reset during DRV_HI of 99.
    valid = 1'b1;
    value = 8'h99;
    step();
    valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst seg1", {1'b0, s1_0}, 8'h7F);
    check("arst seg2", {1'b0, s2_0}, 8'h7F);
    check("arst ready", {7'b0, ready0}, 8'h01);
    check("arst dnum", {4'b0, dnum0}, 8'h00);
    model_reset();
    #3 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      cmp_model("post arst");
      check("no 99 seg1", {1'b0, s1_0}, 8'h7F);
      check("no 99 seg2", {1'b0, s2_0}, 8'h7F);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_digit_display_ctrl.md
# dual_digit_display_ctrl

Sequencer that drives the board's two 7-segment digits from an 8-bit value using a single shared, registered binary-to-7-segment decoder. It accepts a new value over a valid/ready handshake and time-multiplexes both nibbles through the decoder. It captures each digit's segment code and commits both digits atomically to inverted (active-low) pad outputs. It also provides optional leading-zero blanking and a blink function.

## Interface
- `LZ_BLANK`, default 0: when 1, tens digit is dark if the high nibble is 0.
- `BLINK_CYCLES`, default 12_500_000: clock cycles per blink half-period (0.5 s at 25 MHz); legal range ≥2.
- `i_Clk`  in  1  single system clock; all logic on rising edge.
- `i_Rst_L`  in  1  reset, asynchronous assert, active-low.
- `i_Valid`  in  1  `i_Value` is offered.
- `i_Value`  in  8  [7:4] tens nibble, [3:0] ones nibble.
- `o_Ready`  out  1  controller can accept a value.
- `o_Dec_Num`  out  4  nibble driven to the shared decoder.
- `i_Dec_Seg`  in  7  decoder output, active-high, bit6=A … bit0=G; valid one cycle after `o_Dec_Num`.
- `i_Blink_En`  in  1  enable blinking of both digits.
- `o_Seg1`  out  7  tens digit, active-low, bit6=A … bit0=G.
- `o_Seg2`  out  7  ones digit, same encoding.

## Operation
- States: IDLE → DRV_LO → DRV_HI → CAP_HI → IDLE.
- IDLE:
  - `o_Ready`=1.
  - When `i_Valid`&`o_Ready` at a rising edge, latch `i_Value` into the staging register, set `o_Dec_Num`=lo nibble, go to DRV_LO.
- DRV_LO: set `o_Dec_Num`=hi nibble, go to DRV_HI.
- DRV_HI: capture `i_Dec_Seg` (ones code) into the staging register, go to CAP_HI.
- CAP_HI:
  - Commit `o_Seg2`=~staged ones code.
  - Commit `o_Seg1`=~`i_Dec_Seg`, or 7'h7F if `LZ_BLANK`=1 and the hi nibble is 0.
  - Go to IDLE.
- `o_Ready`=0 in every state except IDLE. `i_Valid` outside IDLE is ignored. Sender must hold `i_Value` until the transfer completes.
- Blink:
  - While `i_Blink_En`=1: counter runs 0..`BLINK_CYCLES`-1; the phase bit toggles on each wrap.
  - While phase=1: both outputs read 7'h7F (dark). The committed codes are retained underneath.
  - While `i_Blink_En`=0: counter=0, phase=0.
  - A commit during the dark phase updates the retained codes; they appear at the next lit phase.
- Reset (any time, including mid-sequence):
  - state=IDLE, `o_Ready`=1, `o_Dec_Num`=0.
  - `o_Seg1`=`o_Seg2`=7'h7F.
  - Staging register and blink counter/phase cleared.
  - The in-flight value is discarded.

## Timing
- Accept at edge E0; `o_Dec_Num`=lo after E0, hi after E1.
- Ones code is captured at E2. Both digits update together at E3: latency 3 cycles from accept.
- `o_Ready` is low after E0, E1 and E2, and high again after E3.
- Maximum throughput: one value per 4 cycles. Back-to-back `i_Valid` is accepted at E0, E4, E8, ….
- All outputs are registered; there is no combinational path from inputs to outputs. The blink mask is applied in the output register, so masking takes effect one cycle after the phase toggles.
- The shared decoder contract is a fixed 1-cycle registered latency with the full 0–F mapping.

## Structure
- Package `seg7_pkg`:
  - state enum;
  - `SEG_DARK`=7'h7F;
  - active-high digit codes 0–F: 7E,30,6D,79,33,5B,5F,70,7F,7B,77,1F,4E,3D,4F,47.
- Sub-module `blink_timer` (parameter `BLINK_CYCLES`; ports `i_Clk`, `i_Rst_L`, `i_En`, `o_Phase`).
- Top-level integration instantiates one decoder next to this block. Decoder instance is not contained in this block.

## Test plan
- Reset released, no stimulus → `o_Seg1`=`o_Seg2`=7'h7F, `o_Ready`=1, `o_Dec_Num`=0.
- `i_Value`=8'h3A accepted at E0 → `o_Dec_Num`=A then 3. At E3 `o_Seg1`=7'h06 and `o_Seg2`=7'h08 change together; `o_Ready` is low for exactly 3 cycles.
- `i_Valid` held high with 8'h12 then 8'hEF → second value accepted at E4, not E1–E3. Final outputs: `o_Seg1`=7'h30, `o_Seg2`=7'h38.
- `LZ_BLANK`=1, value 8'h07 → `o_Seg1`=7'h7F, `o_Seg2`=7'h0F. Then value 8'h00 → `o_Seg1`=7'h7F, `o_Seg2`=7'h01.
- `BLINK_CYCLES`=4, `i_Blink_En`=1 after 8'h55 is committed → outputs alternate 7'h24 and 7'h7F every 4 cycles. Deasserting `i_Blink_En` in the dark phase → 7'h24 next cycle.
- `i_Rst_L` pulsed low during DRV_HI of 8'h99 → outputs dark immediately (asynchronous), `o_Ready`=1 after release, and no commit of 0x99 ever appears.
